// File: rtl/split_target_if.sv
// split_target_if: parallel strobe and handshake bundle between the serial
// target port (master side) and the split_target memory (slave side).
interface split_target_if;
  logic [15:0] target_addr_in;
  logic        target_addr_in_valid;
  logic [7:0]  target_data_in;
  logic        target_data_in_valid;
  logic        bus_rw;
  logic        split_grant;
  logic        target_rw;
  logic        target_ready;
  logic        target_ack;
  logic        target_split_ack;
  logic        split_req;
  logic [7:0]  target_data_out;
  logic        target_data_out_valid;

  modport slave (
    input  target_addr_in, target_addr_in_valid, target_data_in,
           target_data_in_valid, bus_rw, split_grant,
    output target_rw, target_ready, target_ack, target_split_ack,
           split_req, target_data_out, target_data_out_valid
  );

  modport master (
    output target_addr_in, target_addr_in_valid, target_data_in,
           target_data_in_valid, bus_rw, split_grant,
    input  target_rw, target_ready, target_ack, target_split_ack,
           split_req, target_data_out, target_data_out_valid
  );
endinterface

// File: rtl/split_target.sv
// split_target: byte-addressed memory target behind the split-capable serial
// target port. Writes complete in one cycle; reads emulate a slow access.
// Optional macro SPLIT_TARGET_SPLIT_EN: when defined, reads release the bus
// (split ack), wait READ_LATENCY cycles, then re-request it with split_req
// before returning the byte. When undefined, reads simply wait and answer.
module split_target #(
  parameter int         MEM_DEPTH     = 4096,
  parameter int         READ_LATENCY  = 4,
  parameter logic [7:0] OOR_READ_DATA = 8'hFF
) (
  input logic           clk,
  input logic           rst_n,
  split_target_if.slave bus
);

  localparam int          AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int          CW      = $clog2(READ_LATENCY + 1);
  localparam logic [16:0] DEPTH17 = 17'(MEM_DEPTH);

`ifdef SPLIT_TARGET_SPLIT_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_READ_SPLIT, ST_READ_WAIT, ST_SPLIT_REQ, ST_SEND
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_READ_WAIT, ST_SEND
  } state_t;
`endif

  state_t          r_state;
  logic            r_ready;
  logic            r_dir;
  logic [AW-1:0]   r_addr;
  logic            r_oor;
  logic [7:0]      r_wdata;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_rdata;
  logic            r_ack;
  logic [7:0]      r_dout;
  logic            r_dout_valid;
  logic [7:0]      r_mem [MEM_DEPTH];
`ifdef SPLIT_TARGET_SPLIT_EN
  logic            r_split_ack;
  logic            r_split_req;
`endif

  logic            w_oor;
  logic            w_mem_we;

  assign w_oor    = ({1'b0, bus.target_addr_in} >= DEPTH17);
  assign w_mem_we = (r_state == ST_WRITE) && !r_oor;

  // Memory write port; the array itself is deliberately never reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // Transaction FSM with registered handshake and data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_dir        <= 1'b0;
      r_addr       <= '0;
      r_oor        <= 1'b0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_rdata      <= '0;
      r_ack        <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
`ifdef SPLIT_TARGET_SPLIT_EN
      r_split_ack  <= 1'b0;
      r_split_req  <= 1'b0;
`endif
    end else begin
      r_ack        <= 1'b0;
      r_dout_valid <= 1'b0;
      r_ready      <= 1'b0;
`ifdef SPLIT_TARGET_SPLIT_EN
      r_split_ack  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && bus.target_addr_in_valid) begin
            r_ready <= 1'b0;
            r_addr  <= bus.target_addr_in[AW-1:0];
            r_oor   <= w_oor;
            if (bus.target_data_in_valid) begin
              r_dir   <= 1'b1;
              r_wdata <= bus.target_data_in;
              r_state <= ST_WRITE;
            end else begin
              r_dir   <= 1'b0;
`ifdef SPLIT_TARGET_SPLIT_EN
              r_state <= ST_READ_SPLIT;
`else
              r_cnt   <= CW'(READ_LATENCY);
              r_state <= ST_READ_WAIT;
`endif
            end
          end
        end
        ST_WRITE: begin
          r_ack   <= 1'b1;
          r_state <= ST_IDLE;
        end
`ifdef SPLIT_TARGET_SPLIT_EN
        ST_READ_SPLIT: begin
          r_split_ack <= 1'b1;
          r_cnt       <= CW'(READ_LATENCY);
          r_state     <= ST_READ_WAIT;
        end
`endif
        ST_READ_WAIT: begin
          if (r_cnt == CW'(1)) begin
            r_rdata <= r_oor ? OOR_READ_DATA : r_mem[r_addr];
`ifdef SPLIT_TARGET_SPLIT_EN
            r_split_req <= 1'b1;
            r_state     <= ST_SPLIT_REQ;
`else
            r_state     <= ST_SEND;
`endif
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`ifdef SPLIT_TARGET_SPLIT_EN
        ST_SPLIT_REQ: begin
          if (bus.split_grant) begin
            r_split_req <= 1'b0;
            r_state     <= ST_SEND;
          end
        end
`endif
        ST_SEND: begin
          r_dout       <= r_rdata;
          r_dout_valid <= 1'b1;
          r_ack        <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.target_rw             = (r_state == ST_IDLE) ? bus.bus_rw : r_dir;
  assign bus.target_ready          = r_ready;
  assign bus.target_ack            = r_ack;
  assign bus.target_data_out       = r_dout;
  assign bus.target_data_out_valid = r_dout_valid;
`ifdef SPLIT_TARGET_SPLIT_EN
  assign bus.target_split_ack      = r_split_ack;
  assign bus.split_req             = r_split_req;
`else
  logic w_unused_grant;
  assign w_unused_grant            = bus.split_grant;
  assign bus.target_split_ack      = 1'b0;
  assign bus.split_req             = 1'b0;
`endif

endmodule

// File: tb/tb_split_target.sv
// tb_split_target: randomized and directed checks of split_target against a
// transaction-level model (byte map plus cycle-offset arithmetic).
`timescale 1ns/1ps
module tb_split_target;
  localparam int         MD  = 4096;
  localparam int         RL  = 4;
  localparam logic [7:0] OOR = 8'hFF;
`ifdef SPLIT_TARGET_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [7:0] model_mem [int];

  split_target_if bus_if();

  split_target #(.MEM_DEPTH(MD), .READ_LATENCY(RL), .OOR_READ_DATA(OOR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop if something hangs despite the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_valid_k(input int gdelay);
    return SPLIT ? (RL + 2 + gdelay + 2) : (RL + 2);
  endfunction

  task automatic model_write(input logic [15:0] addr, input logic [7:0] data);
    if (int'(addr) < MD) model_mem[int'(addr)] = data;
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    if (int'(addr) >= MD) return OOR;
    return model_mem[int'(addr)];
  endfunction

  task automatic clear_inputs();
    bus_if.target_addr_in_valid = 1'b0;
    bus_if.target_data_in_valid = 1'b0;
    bus_if.split_grant          = 1'b0;
  endtask

  task automatic run_write(input logic [15:0] addr, input logic [7:0] data,
                           output bit rdy, output int ack_k, output int ack_n);
    ack_k = -1; ack_n = 0;
    for (int i = 0; i < 50 && bus_if.target_ready !== 1'b1; i++) tick();
    rdy = (bus_if.target_ready === 1'b1);
    bus_if.target_addr_in = addr;
    bus_if.target_data_in = data;
    bus_if.target_addr_in_valid = 1'b1;
    bus_if.target_data_in_valid = 1'b1;
    bus_if.bus_rw = 1'b1;
    tick();
    clear_inputs();
    for (int k = 1; k <= 6; k++) begin
      if (bus_if.target_ack === 1'b1) begin
        ack_n++;
        if (ack_k < 0) ack_k = k;
      end
      tick();
    end
    model_write(addr, data);
  endtask

  task automatic run_read(input logic [15:0] addr, input int gdelay, input int stray_k,
                          output bit rdy, output logic [7:0] data, output logic [7:0] hold,
                          output int valid_k, output int ack_n, output int sack_k,
                          output int sack_n, output int sreq_k, output int sreq_fall_k,
                          output int ready_busy);
    data = '0; hold = '0; valid_k = -1; ack_n = 0; sack_k = -1; sack_n = 0;
    sreq_k = -1; sreq_fall_k = -1; ready_busy = 0;
    for (int i = 0; i < 50 && bus_if.target_ready !== 1'b1; i++) tick();
    rdy = (bus_if.target_ready === 1'b1);
    bus_if.target_addr_in = addr;
    bus_if.target_addr_in_valid = 1'b1;
    bus_if.target_data_in_valid = 1'b0;
    bus_if.bus_rw = 1'b0;
    tick();
    for (int k = 1; k <= 80 + gdelay; k++) begin
      clear_inputs();
      if (bus_if.target_split_ack === 1'b1) begin
        sack_n++;
        if (sack_k < 0) sack_k = k;
      end
      if (bus_if.split_req === 1'b1 && sreq_k < 0) sreq_k = k;
      if (sreq_k >= 0 && bus_if.split_req !== 1'b1 && sreq_fall_k < 0) sreq_fall_k = k;
      if (bus_if.target_ack === 1'b1) ack_n++;
      if (bus_if.target_data_out_valid === 1'b1 && valid_k < 0) begin
        valid_k = k;
        data = bus_if.target_data_out;
      end
      if (valid_k >= 0 && k == valid_k + 1) hold = bus_if.target_data_out;
      if (valid_k < 0 && bus_if.target_ready === 1'b1) ready_busy++;
      if (sreq_k >= 0 && sreq_fall_k < 0 && k == sreq_k + gdelay) bus_if.split_grant = 1'b1;
      if (k == stray_k) begin
        bus_if.target_addr_in = 16'h0123;
        bus_if.target_data_in = 8'h77;
        bus_if.target_addr_in_valid = 1'b1;
        bus_if.target_data_in_valid = 1'b1;
      end
      if (valid_k >= 0 && k >= valid_k + 4) break;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.bus_rw = 1'b0;
    clear_inputs();
    tick(); tick();
    tests_run++;
    if ({bus_if.target_ready, bus_if.target_ack, bus_if.target_split_ack, bus_if.split_req,
         bus_if.target_data_out, bus_if.target_data_out_valid, bus_if.target_rw} !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got ready=%b ack=%b sack=%b sreq=%b dout=%h dv=%b rw=%b, expected all 0",
               bus_if.target_ready, bus_if.target_ack, bus_if.target_split_ack, bus_if.split_req,
               bus_if.target_data_out, bus_if.target_data_out_valid, bus_if.target_rw);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (bus_if.target_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready_before_edge: got %b expected 0", bus_if.target_ready);
    end
    tick();
    tests_run++;
    if (bus_if.target_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready_after_edge: got %b expected 1", bus_if.target_ready);
    end
  endtask

  task automatic test_write_read();
    bit rdy; int ack_k, ack_n, vk, sk, sn, rk, fk, rb; logic [7:0] d, h;
    run_write(16'h0123, 8'hA5, rdy, ack_k, ack_n);
    tests_run++;
    if (ack_k !== 2 || ack_n !== 1) begin
      tests_failed++;
      $display("[TB] FAIL wr_ack: got k=%0d n=%0d expected k=2 n=1", ack_k, ack_n);
    end
    run_read(16'h0123, 3, -1, rdy, d, h, vk, ack_n, sk, sn, rk, fk, rb);
    tests_run++;
    if (d !== model_read(16'h0123) || vk !== exp_valid_k(3)) begin
      tests_failed++;
      $display("[TB] FAIL rd_data: got %h at k=%0d expected %h at k=%0d", d, vk, model_read(16'h0123), exp_valid_k(3));
    end
    tests_run++;
    if (sk !== (SPLIT ? 2 : -1) || sn !== (SPLIT ? 1 : 0)) begin
      tests_failed++;
      $display("[TB] FAIL rd_split_ack: got k=%0d n=%0d expected k=%0d n=%0d", sk, sn, SPLIT ? 2 : -1, SPLIT ? 1 : 0);
    end
    tests_run++;
    if (rk !== (SPLIT ? RL + 2 : -1) || fk !== (SPLIT ? RL + 2 + 3 + 1 : -1)) begin
      tests_failed++;
      $display("[TB] FAIL rd_split_req: got rise=%0d fall=%0d expected rise=%0d fall=%0d",
               rk, fk, SPLIT ? RL + 2 : -1, SPLIT ? RL + 6 : -1);
    end
    tests_run++;
    if (ack_n !== 1 || h !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL rd_ack_hold: got acks=%0d hold=%h expected acks=1 hold=a5", ack_n, h);
    end
  endtask

  task automatic test_out_of_range();
    bit rdy; int ack_k, ack_n, vk, sk, sn, rk, fk, rb; logic [7:0] d, h;
    run_write(16'h0000, 8'h5A, rdy, ack_k, ack_n);
    run_read(16'h2000, 1, -1, rdy, d, h, vk, ack_n, sk, sn, rk, fk, rb);
    tests_run++;
    if (d !== OOR || vk !== exp_valid_k(1)) begin
      tests_failed++;
      $display("[TB] FAIL oor_read: got %h at k=%0d expected %h at k=%0d", d, vk, OOR, exp_valid_k(1));
    end
    run_write(16'h2000, 8'h11, rdy, ack_k, ack_n);
    tests_run++;
    if (ack_k !== 2 || ack_n !== 1) begin
      tests_failed++;
      $display("[TB] FAIL oor_write_ack: got k=%0d n=%0d expected k=2 n=1", ack_k, ack_n);
    end
    run_read(16'h0000, 0, -1, rdy, d, h, vk, ack_n, sk, sn, rk, fk, rb);
    tests_run++;
    if (d !== model_read(16'h0000)) begin
      tests_failed++;
      $display("[TB] FAIL oor_no_alias: got %h expected %h", d, model_read(16'h0000));
    end
  endtask

  task automatic test_ignored();
    bit rdy; int ack_k, ack_n, vk, sk, sn, rk, fk, rb, spurious; logic [7:0] d, h;
    spurious = 0;
    for (int i = 0; i < 50 && bus_if.target_ready !== 1'b1; i++) tick();
    bus_if.split_grant = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus_if.split_req !== 1'b0 || bus_if.target_ack !== 1'b0 ||
          bus_if.target_data_out_valid !== 1'b0 || bus_if.target_ready !== 1'b1) spurious++;
    end
    bus_if.split_grant = 1'b0;
    tests_run++;
    if (spurious !== 0) begin
      tests_failed++;
      $display("[TB] FAIL stray_grant_idle: got %0d bad windows expected 0", spurious);
    end
    run_read(16'h0000, 2, 4, rdy, d, h, vk, ack_n, sk, sn, rk, fk, rb);
    tests_run++;
    if (rb !== 0 || ack_n !== 1 || vk !== exp_valid_k(2)) begin
      tests_failed++;
      $display("[TB] FAIL stray_strobe_busy: got ready_busy=%0d acks=%0d k=%0d expected 0 1 %0d",
               rb, ack_n, vk, exp_valid_k(2));
    end
    run_read(16'h0123, 0, -1, rdy, d, h, vk, ack_n, sk, sn, rk, fk, rb);
    tests_run++;
    if (d !== model_read(16'h0123)) begin
      tests_failed++;
      $display("[TB] FAIL stray_strobe_no_write: got %h expected %h", d, model_read(16'h0123));
    end
  endtask

  task automatic test_rw();
    for (int i = 0; i < 50 && bus_if.target_ready !== 1'b1; i++) tick();
    bus_if.bus_rw = 1'b1; #1;
    tests_run++;
    if (bus_if.target_rw !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rw_idle_high: got %b expected 1", bus_if.target_rw);
    end
    bus_if.bus_rw = 1'b0; #1;
    tests_run++;
    if (bus_if.target_rw !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rw_idle_low: got %b expected 0", bus_if.target_rw);
    end
    bus_if.target_addr_in = 16'h0200;
    bus_if.target_data_in = 8'h5C;
    bus_if.target_addr_in_valid = 1'b1;
    bus_if.target_data_in_valid = 1'b1;
    bus_if.bus_rw = 1'b1;
    tick();
    clear_inputs();
    model_write(16'h0200, 8'h5C);
    bus_if.bus_rw = 1'b0; #1;
    tests_run++;
    if (bus_if.target_rw !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rw_held: got %b expected 1", bus_if.target_rw);
    end
    tick();
    tests_run++;
    if (bus_if.target_rw !== 1'b0 || bus_if.target_ack !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rw_release: got rw=%b ack=%b expected rw=0 ack=1", bus_if.target_rw, bus_if.target_ack);
    end
  endtask

  task automatic test_back_to_back();
    bit rdy; int ack_k, ack_n, vk, sk, sn, rk, fk, rb, activity; logic [7:0] d, h;
    activity = 0;
    for (int i = 0; i < 50 && bus_if.target_ready !== 1'b1; i++) tick();
    bus_if.target_addr_in = 16'h0300;
    bus_if.target_data_in = 8'h42;
    bus_if.target_addr_in_valid = 1'b1;
    bus_if.target_data_in_valid = 1'b1;
    bus_if.bus_rw = 1'b1;
    tick();
    clear_inputs();
    model_write(16'h0300, 8'h42);
    tick();
    tests_run++;
    if (bus_if.target_ack !== 1'b1 || bus_if.target_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ack_window: got ack=%b ready=%b expected ack=1 ready=0",
               bus_if.target_ack, bus_if.target_ready);
    end
    bus_if.target_addr_in_valid = 1'b1;
    bus_if.bus_rw = 1'b0;
    tick();
    clear_inputs();
    tests_run++;
    if (bus_if.target_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_early_strobe: got ready=%b expected 1", bus_if.target_ready);
    end
    for (int k = 0; k < 12; k++) begin
      if (bus_if.target_ack === 1'b1 || bus_if.target_split_ack === 1'b1 ||
          bus_if.target_data_out_valid === 1'b1) activity++;
      tick();
    end
    tests_run++;
    if (activity !== 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_ignored: got %0d active windows expected 0", activity);
    end
    run_write(16'h0301, 8'h24, rdy, ack_k, ack_n);
    run_read(16'h0300, 1, -1, rdy, d, h, vk, ack_n, sk, sn, rk, fk, rb);
    tests_run++;
    if (d !== model_read(16'h0300) || vk !== exp_valid_k(1)) begin
      tests_failed++;
      $display("[TB] FAIL b2b_read: got %h at k=%0d expected %h at k=%0d", d, vk, model_read(16'h0300), exp_valid_k(1));
    end
  endtask

  task automatic test_reset_abort();
    bit rdy, reached; int ack_k, ack_n, vk, sk, sn, rk, fk, rb, late; logic [7:0] d, h;
    late = 0; reached = 0;
    run_write(16'h0010, 8'h3C, rdy, ack_k, ack_n);
    bus_if.target_addr_in = 16'h0010;
    bus_if.target_addr_in_valid = 1'b1;
    bus_if.bus_rw = 1'b0;
    tick();
    clear_inputs();
    for (int k = 1; k <= 30 && !reached; k++) begin
      if (SPLIT ? (bus_if.split_req === 1'b1) : (k == 3)) reached = 1'b1;
      else tick();
    end
    tests_run++;
    if (reached !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL abort_reach: got %b expected 1", reached);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus_if.split_req, bus_if.target_ack, bus_if.target_ready, bus_if.target_data_out_valid} !== 4'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_async: got sreq=%b ack=%b ready=%b dv=%b expected all 0",
               bus_if.split_req, bus_if.target_ack, bus_if.target_ready, bus_if.target_data_out_valid);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus_if.target_ack === 1'b1 || bus_if.target_data_out_valid === 1'b1 ||
          bus_if.split_req === 1'b1) late++;
    end
    tests_run++;
    if (late !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_late: got %0d windows expected 0", late);
    end
    run_read(16'h0010, 2, -1, rdy, d, h, vk, ack_n, sk, sn, rk, fk, rb);
    tests_run++;
    if (d !== model_read(16'h0010) || vk !== exp_valid_k(2)) begin
      tests_failed++;
      $display("[TB] FAIL abort_reread: got %h at k=%0d expected %h at k=%0d", d, vk, model_read(16'h0010), exp_valid_k(2));
    end
  endtask

  task automatic test_random();
    bit rdy; int ack_k, ack_n, vk, sk, sn, rk, fk, rb, gd; logic [7:0] d, h, wd;
    logic [15:0] pool [6];
    logic [15:0] a;
    for (int i = 0; i < 6; i++) pool[i] = 16'($urandom_range(0, MD - 1));
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(MD, 16'hFFFF));
      else a = pool[$urandom_range(0, 5)];
      wd = 8'($urandom);
      if ($urandom_range(0, 1) == 1 || (int'(a) < MD && !model_mem.exists(int'(a)))) begin
        run_write(a, wd, rdy, ack_k, ack_n);
        tests_run++;
        if (ack_k !== 2 || ack_n !== 1 || rdy !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL rand_write %h: got k=%0d n=%0d expected k=2 n=1", a, ack_k, ack_n);
        end
      end else begin
        gd = $urandom_range(0, 5);
        run_read(a, gd, -1, rdy, d, h, vk, ack_n, sk, sn, rk, fk, rb);
        tests_run++;
        if (d !== model_read(a) || vk !== exp_valid_k(gd) || ack_n !== 1) begin
          tests_failed++;
          $display("[TB] FAIL rand_read %h: got %h k=%0d acks=%0d expected %h k=%0d acks=1",
                   a, d, vk, ack_n, model_read(a), exp_valid_k(gd));
        end
      end
    end
  endtask

  initial begin
    bus_if.target_addr_in = '0;
    bus_if.target_data_in = '0;
    bus_if.bus_rw = 1'b0;
    clear_inputs();
    test_reset();
    test_write_read();
    test_out_of_range();
    test_ignored();
    test_rw();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
